// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: EX/ID forward selects,
// load-use and branch stalls, and a fixed-latency divide stall sequencer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no divide in flight; div_start launches one
// DIV_BUSY | divide held in EX; stalls while cnt!=0, done when cnt==0
module hazard_fwd_ctrl #(
    parameter int AW         = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_branch,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] ex_wreg,
    input  logic          ex_regwrite,
    input  logic          ex_memtoreg,
    input  logic [AW-1:0] mem_wreg,
    input  logic          mem_regwrite,
    input  logic          mem_memtoreg,
    input  logic [AW-1:0] wb_wreg,
    input  logic          wb_regwrite,
    input  logic          div_start,
    input  logic          exc_flush,
    output logic [1:0]    fwd_ae,
    output logic [1:0]    fwd_be,
    output logic          fwd_ad,
    output logic          fwd_bd,
    output logic          stall_f,
    output logic          stall_d,
    output logic          stall_e,
    output logic          flush_e,
    output logic          flush_m,
    output logic          div_busy,
    output logic          div_done
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] DIV_BUSY = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [AW-1:0]    REG_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lwstall;
    logic brstall;
    logic divstall;
    logic cnt_zero;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != REG_ZERO && mem_regwrite && mem_wreg == src)
            sel = FWD_MEM;
        else if (src != REG_ZERO && wb_regwrite && wb_wreg == src)
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        fwd_ae = fwd_sel(ex_rs);
        fwd_be = fwd_sel(ex_rt);
        fwd_ad = (id_rs != REG_ZERO) && mem_regwrite && (mem_wreg == id_rs);
        fwd_bd = (id_rt != REG_ZERO) && mem_regwrite && (mem_wreg == id_rt);
    end

    always_comb begin
        lwstall = ex_memtoreg && (ex_wreg != REG_ZERO)
                  && ((ex_wreg == id_rs) || (ex_wreg == id_rt));
        brstall = id_branch
                  && ((ex_regwrite && (ex_wreg != REG_ZERO)
                       && ((ex_wreg == id_rs) || (ex_wreg == id_rt)))
                   || (mem_memtoreg && (mem_wreg != REG_ZERO)
                       && ((mem_wreg == id_rs) || (mem_wreg == id_rt))));
    end

    assign cnt_zero = (cnt_q == CNT_ZERO);
    assign divstall = ((state_q == IDLE) && div_start)
                      || ((state_q == DIV_BUSY) && !cnt_zero);

    // Divide stall freezes EX, so a concurrent load-use bubble must not be injected.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (!exc_flush) begin
            stall_f = divstall | lwstall | brstall;
            stall_d = divstall | lwstall | brstall;
            stall_e = divstall;
            flush_m = divstall;
            flush_e = (lwstall | brstall) & ~divstall;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_flush) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        state_d = DIV_BUSY;
                        cnt_d   = DIV_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_zero) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign div_busy = (state_q == DIV_BUSY);
    assign div_done = (state_q == DIV_BUSY) && cnt_zero && !exc_flush;

endmodule
